// File: rtl/mem_arbiter.sv
// Arbiter for a single-ported unified memory shared by instruction fetch and
// data (load/store). One command is in flight at a time. Data requests win
// over fetch until STARVE_MAX consecutive data grants have passed a waiting
// fetch; then fetch is forced through.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | arbitrate between if_req and d_req, latch winner's command
// ISSUE | one-cycle mem_req strobe, clear the timeout counter
// WAIT  | wait for mem_rvalid; abort after TIMEOUT cycles and set err
// RESP  | one-cycle valid pulse to the owning port, no arbitration

module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_type,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              d_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
    localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);
    localparam logic [2:0] TYPE_WORD  = 3'b010;

    state_t     state;
    state_t     state_next;
    logic       grant_d;
    logic       grant_f;
    logic       done_ok;
    logic       done_to;
    logic [3:0] starve_cnt;
    logic [7:0] to_cnt;
    logic       owner;      // 1 = data port owns the access, 0 = fetch

    // Stalls are the only combinational outputs.
    assign if_stall = if_req & ~if_valid;
    assign d_stall  = d_req & ~d_valid;

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, arbitration and completion decode.
    always_comb begin
        state_next = state;
        grant_d    = 1'b0;
        grant_f    = 1'b0;
        done_ok    = 1'b0;
        done_to    = 1'b0;
        case (state)
            IDLE: begin
                if (d_req && (!if_req || (starve_cnt < STARVE_LIM))) begin
                    grant_d    = 1'b1;
                    state_next = ISSUE;
                end else if (if_req) begin
                    grant_f    = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (mem_rvalid) begin
                    done_ok    = 1'b1;
                    state_next = RESP;
                end else if (to_cnt == TO_LAST) begin
                    done_to    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Starvation counter: counts data grants that passed a waiting fetch.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            starve_cnt <= 4'd0;
        end else if (grant_f) begin
            starve_cnt <= 4'd0;
        end else if (grant_d && if_req) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Command registers: latched on grant and held until the next grant.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            owner     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_type  <= 3'b000;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_req <= grant_d | grant_f;
            if (grant_d) begin
                owner     <= 1'b1;
                mem_we    <= d_we;
                mem_type  <= d_type;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (grant_f) begin
                owner     <= 1'b0;
                mem_we    <= 1'b0;
                mem_type  <= TYPE_WORD;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
            end
        end
    end

    // Timeout counter: cleared while issuing, counts cycles spent in WAIT.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            to_cnt <= 8'd0;
        end else if (state == ISSUE) begin
            to_cnt <= 8'd0;
        end else if (state == WAIT) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    // Response path: capture data (or zero on timeout) into the owner's port.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            if_rdata <= '0;
            if_valid <= 1'b0;
            d_rdata  <= '0;
            d_valid  <= 1'b0;
            err      <= 1'b0;
        end else begin
            if_valid <= (done_ok | done_to) & ~owner;
            d_valid  <= (done_ok | done_to) & owner;
            if (done_ok || done_to) begin
                if (owner) begin
                    d_rdata <= done_ok ? mem_rdata : '0;
                end else begin
                    if_rdata <= done_ok ? mem_rdata : '0;
                end
            end
            if (done_to) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single-ported unified memory shared between the instruction-fetch port and the data (load/store) port of the core.
- Selects one requester at a time and issues a one-cycle memory command. It then waits for the memory response and returns the data to the winning requester with a one-cycle valid pulse.
- Drives per-port stall signals so fetch and the memory stage can freeze.
- Data accesses have priority, bounded by an anti-starvation counter so fetch always makes progress.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants that may pass over a waiting fetch before fetch is forced; legal range 1..15
- TIMEOUT, 16, WAIT cycles without mem_rvalid before the access is aborted; legal range 2..255

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, ACTIVE-HIGH (name kept per codebase convention; asserted = 1)
- if_req  in  1  fetch request; held with if_addr stable until if_valid
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, valid with if_valid
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_valid
- d_req  in  1  data request; held with d_we/d_type/d_addr/d_wdata stable until d_valid
- d_we  in  1  1 = store, 0 = load
- d_type  in  3  memType encoding, passed through unmodified
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid with d_valid
- d_valid  out  1  one-cycle data completion pulse (loads and stores)
- d_stall  out  1  d_req & ~d_valid
- mem_req  out  1  one-cycle command strobe
- mem_we  out  1  write enable of issued command
- mem_type  out  3  memType of issued command (3'b010 word for fetch)
- mem_addr  out  ADDR_W  command address
- mem_wdata  out  DATA_W  command write data (0 for fetch)
- mem_rvalid  in  1  response/ack; sampled only in WAIT
- mem_rdata  in  DATA_W  response data, valid with mem_rvalid
- err  out  1  sticky timeout flag

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except the stalls.
- Reset, asynchronous: state=IDLE; starve_cnt=0; owner=0; all command and response outputs 0; err=0. A reset mid-access abandons the access. A late mem_rvalid after reset is ignored because it arrives outside WAIT.
- IDLE arbitration:
  - d_req only -> grant data.
  - if_req only -> grant fetch.
  - Both, with starve_cnt<STARVE_MAX -> grant data, starve_cnt++.
  - Both, with starve_cnt==STARVE_MAX -> grant fetch.
  - Any fetch grant clears starve_cnt. A data grant with if_req low leaves starve_cnt unchanged.
  - On grant: latch the winner's command into the mem_* registers, record owner, go to ISSUE.
- ISSUE, one cycle: mem_req=1 with mem_* valid. Next state is WAIT; the timeout counter is cleared.
- WAIT: mem_req=0 while the mem_* fields hold.
  - mem_rvalid=1 -> capture mem_rdata into the owner's rdata, go to RESP.
  - Otherwise the counter increments. At count TIMEOUT: go to RESP with rdata=0 and set err (sticky until reset).
- RESP, one cycle: owner's valid=1; the other port's valid stays 0. Next state is IDLE.
  - No arbitration happens in RESP. The requester may drop or update its request at the edge ending RESP.
- Latency: request seen in IDLE at cycle N -> mem_req at N+1 -> rvalid earliest at N+2 -> valid at N+3. Minimum of 4 cycles per access.
- mem_rvalid in IDLE, ISSUE or RESP is ignored.
- Stores complete the same way, on mem_rvalid acting as an ack. d_rdata is then the captured mem_rdata and is don't-care to the core.
- Requests must not be withdrawn before valid. Behaviour is undefined if a request is dropped mid-access, except that the FSM still returns to IDLE via RESP.
- rdata registers hold their value until the next completion for that port.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, mem_rvalid one cycle after mem_req with mem_rdata=0x00500093 -> mem_req pulse at N+1 with mem_addr=0x100, mem_we=0, mem_type=3'b010; if_valid at N+3 with if_rdata=0x00500093; if_stall high N..N+2.
- Store: d_req=1, d_we=1, d_type=3'b010, d_addr=0x2000, d_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF, mem_addr=0x2000; d_valid one cycle after the ack; no if_valid.
- Contention and starvation: both requests held continuously with immediate acks, STARVE_MAX=4 -> grant order D,D,D,D,F,D,D,D,D,F; starve_cnt reads 0 after each F.
- Timeout: d_req load, mem_rvalid never asserted, TIMEOUT=16 -> d_valid 16 cycles after WAIT entry with d_rdata=0; err=1 and stays 1 through later good accesses.
- Reset mid-WAIT: assert rst_n for 1 cycle during WAIT, then drive mem_rvalid=1 -> no valid pulse, mem_req=0, state IDLE, err=0; the next request is served normally.
- Stray rvalid: mem_rvalid=1 in IDLE and in the ISSUE cycle -> ignored; completion occurs only on the WAIT-cycle rvalid.
